// File: rtl/dma_engine_pkg.sv
// Shared state encodings and index-width helper for the round-robin DMA copy engine.
// Latency: none, types and constants only.
// Backpressure: not applicable.
package dma_engine_pkg;

  typedef enum logic [2:0] {
    ST_ARB,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR,
    ST_STEP
  } eng_state_e;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_PENDING,
    CH_DONE_WAIT
  } ch_state_e;

  // Channel index width, never narrower than one bit so a single-channel build still has a port.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CHANNELS_AMOUNT_DEF = 4;
  localparam int CH_IDX_W = ch_idx_w(CHANNELS_AMOUNT_DEF);

endpackage

// File: rtl/dma_rr_arbiter.sv
// Round-robin pick of the first pending channel at or after rr_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; gnt_vld simply drops when nothing is pending.
module dma_rr_arbiter
  import dma_engine_pkg::*;
#(
  parameter int CHANNELS_AMOUNT = 4,
  parameter int CH_W = ch_idx_w(CHANNELS_AMOUNT)
) (
  input  logic [CHANNELS_AMOUNT-1:0] pending,
  input  logic [CH_W-1:0]            rr_ptr,
  output logic [CH_W-1:0]            gnt_idx,
  output logic                       gnt_vld
);

  logic [CHANNELS_AMOUNT-1:0] rotated;
  int first;
  int sum;

  // Rotate so bit 0 is the channel at rr_ptr, then take the lowest set bit.
  always_comb begin
    rotated = CHANNELS_AMOUNT'({pending, pending} >> rr_ptr);
    gnt_vld = |rotated;
    first   = 0;
    for (int j = CHANNELS_AMOUNT - 1; j >= 0; j--) begin
      if (rotated[j]) first = j;
    end
    sum = int'(rr_ptr) + first;
    if (sum >= CHANNELS_AMOUNT) sum = sum - CHANNELS_AMOUNT;
    gnt_idx = CH_W'(sum);
  end

endmodule

// File: rtl/dma_rr_copy_engine.sv
// Multi-channel memory-to-memory copy engine sharing one Avalon read and one write master.
// Latency: request to first read 2 cycles; 4 cycles per unstalled word; ack 1 cycle after last STEP.
// Backpressure: rd/wr waitrequest hold the strobe, address and data; one read outstanding.
module dma_rr_copy_engine
  import dma_engine_pkg::*;
#(
  parameter int CHANNELS_AMOUNT = 4,
  parameter int DATA_W          = 64,
  parameter int ADDR_W          = 32,
  parameter int LEN_W           = 16,
  parameter int BURST_WORDS     = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [CHANNELS_AMOUNT-1:0]          request_i,
  output logic [CHANNELS_AMOUNT-1:0]          acknowledge_o,
  input  logic [CHANNELS_AMOUNT*ADDR_W-1:0]   cfg_src_addr_i,
  input  logic [CHANNELS_AMOUNT*ADDR_W-1:0]   cfg_dst_addr_i,
  input  logic [CHANNELS_AMOUNT*LEN_W-1:0]    cfg_len_i,
  output logic [ADDR_W-1:0]                   rd_address_o,
  output logic                                rd_read_o,
  input  logic                                rd_waitrequest_i,
  input  logic [DATA_W-1:0]                   rd_readdata_i,
  input  logic                                rd_readdatavalid_i,
  output logic [ADDR_W-1:0]                   wr_address_o,
  output logic                                wr_write_o,
  output logic [DATA_W-1:0]                   wr_writedata_o,
  output logic [DATA_W/8-1:0]                 wr_byteenable_o,
  input  logic                                wr_waitrequest_i,
  output logic                                busy_o,
  output logic [ch_idx_w(CHANNELS_AMOUNT)-1:0] active_ch_o
);

  localparam int CH_W = ch_idx_w(CHANNELS_AMOUNT);
  localparam int SL_W = $clog2(BURST_WORDS + 1);
  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(DATA_W / 8);

  typedef struct packed {
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  len;
  } desc_t;

  desc_t                      desc_q  [CHANNELS_AMOUNT];
  ch_state_e                  ch_st_q [CHANNELS_AMOUNT];
  logic [CHANNELS_AMOUNT-1:0] pending;
  eng_state_e                 state_q, state_d;
  logic [CH_W-1:0]            gnt_q, rr_ptr_q, arb_idx, done_idx, end_idx;
  logic                       arb_vld;
  logic [SL_W-1:0]            slice_q;
  logic [DATA_W-1:0]          data_q;
  logic [CHANNELS_AMOUNT-1:0] ack_q;
  logic                       grant_take, step_fire, done_vld, grant_end;
  logic                       last_word, slice_full;
  desc_t                      cur;

  assign cur = desc_q[gnt_q];

  always_comb begin
    pending = '0;
    for (int i = 0; i < CHANNELS_AMOUNT; i++) begin
      pending[i] = (ch_st_q[i] == CH_PENDING);
    end
  end

  dma_rr_arbiter #(
    .CHANNELS_AMOUNT (CHANNELS_AMOUNT),
    .CH_W            (CH_W)
  ) u_arb (
    .pending (pending),
    .rr_ptr  (rr_ptr_q),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_ARB;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    grant_take = 1'b0;
    step_fire  = 1'b0;
    done_vld   = 1'b0;
    done_idx   = gnt_q;
    grant_end  = 1'b0;
    end_idx    = gnt_q;
    last_word  = (cur.len == LEN_W'(1));
    slice_full = (slice_q == SL_W'(BURST_WORDS - 1));
    case (state_q)
      ST_ARB: begin
        if (arb_vld) begin
          // Zero-length descriptors complete straight from arbitration, never touching the bus.
          if (desc_q[arb_idx].len == '0) begin
            done_vld  = 1'b1;
            done_idx  = arb_idx;
            grant_end = 1'b1;
            end_idx   = arb_idx;
          end else begin
            grant_take = 1'b1;
            state_d    = ST_RD_REQ;
          end
        end
      end
      ST_RD_REQ:  if (!rd_waitrequest_i)  state_d = ST_RD_WAIT;
      ST_RD_WAIT: if (rd_readdatavalid_i) state_d = ST_WR;
      ST_WR:      if (!wr_waitrequest_i)  state_d = ST_STEP;
      ST_STEP: begin
        step_fire = 1'b1;
        if (last_word) begin
          done_vld  = 1'b1;
          grant_end = 1'b1;
          state_d   = ST_ARB;
        end else if (slice_full) begin
          grant_end = 1'b1;
          state_d   = ST_ARB;
        end else begin
          state_d = ST_RD_REQ;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      slice_q  <= '0;
      data_q   <= '0;
      ack_q    <= '0;
    end else begin
      ack_q <= '0;
      if (grant_take) begin
        gnt_q   <= arb_idx;
        slice_q <= '0;
      end else if (step_fire) begin
        slice_q <= slice_q + 1'b1;
      end
      if (state_q == ST_RD_WAIT && rd_readdatavalid_i) data_q <= rd_readdata_i;
      if (grant_end) rr_ptr_q <= (end_idx == CH_W'(CHANNELS_AMOUNT - 1)) ? '0 : end_idx + 1'b1;
      if (done_vld) ack_q[done_idx] <= 1'b1;
    end
  end

  // Progress lives in the channel's own descriptor, so a preempted channel resumes where it stopped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < CHANNELS_AMOUNT; i++) begin
        ch_st_q[i] <= CH_IDLE;
        desc_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS_AMOUNT; i++) begin
        case (ch_st_q[i])
          CH_IDLE: begin
            if (request_i[i]) begin
              desc_q[i].src <= cfg_src_addr_i[i*ADDR_W +: ADDR_W];
              desc_q[i].dst <= cfg_dst_addr_i[i*ADDR_W +: ADDR_W];
              desc_q[i].len <= cfg_len_i[i*LEN_W +: LEN_W];
              ch_st_q[i]    <= CH_PENDING;
            end
          end
          CH_PENDING: begin
            if (step_fire && gnt_q == CH_W'(i)) begin
              desc_q[i].src <= desc_q[i].src + WORD_BYTES;
              desc_q[i].dst <= desc_q[i].dst + WORD_BYTES;
              desc_q[i].len <= desc_q[i].len - 1'b1;
            end
            if (done_vld && done_idx == CH_W'(i)) ch_st_q[i] <= CH_DONE_WAIT;
          end
          CH_DONE_WAIT: if (!request_i[i]) ch_st_q[i] <= CH_IDLE;
          default: ch_st_q[i] <= CH_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rd_read_o       = (state_q == ST_RD_REQ);
    wr_write_o      = (state_q == ST_WR);
    busy_o          = (state_q != ST_ARB);
    active_ch_o     = gnt_q;
    rd_address_o    = cur.src;
    wr_address_o    = cur.dst;
    wr_writedata_o  = data_q;
    wr_byteenable_o = '1;
    acknowledge_o   = ack_q;
  end

endmodule
